// File: rtl/counter_gray_rx_pkg.sv
// Shared definitions for the Gray-coded counter receiver.
//   state_t  : receiver FSM states (S_INIT, S_TRACK, S_RESYNC)
//   ERRCNT_W : width of the optional saturating illegal-event counter
package counter_gray_rx_pkg;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_TRACK  = 2'd1,
        S_RESYNC = 2'd2
    } state_t;

    localparam int unsigned ERRCNT_W = 8;

endpackage

// File: rtl/counter_gray2bin.sv
// Pure combinational Gray-to-binary converter.
// Parameters:
//   BUS_WIDTH : code width (>=2)
// Ports:
//   gray : Gray-coded input
//   bin  : binary equivalent
module counter_gray2bin #(
    parameter int unsigned BUS_WIDTH = 4
) (
    input  logic [BUS_WIDTH-1:0] gray,
    output logic [BUS_WIDTH-1:0] bin
);

    // Binary bit i is the XOR of all Gray bits at position i and above.
    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/counter_gray_rx.sv
// Destination-domain receiver for a bit-synchronised Gray-coded counter bus.
// The bus is registered, converted to binary and only +1 steps are accepted;
// each accepted step produces a one-cycle o_inc pulse. Any other change flags
// o_err (sticky) and the receiver waits for the bus to be stable before
// taking a fresh baseline.
// Parameters:
//   BUS_WIDTH     : counter width (>=2)
//   STABLE_CYCLES : consecutive identical samples needed for a baseline (>=1)
// Ports:
//   i_clk      : clock, all logic on posedge
//   i_rst      : synchronous active-high reset
//   i_gray     : synchronised Gray-coded counter value
//   i_clr_err  : level clear for o_err (and o_err_cnt when present)
//   o_bin      : last accepted counter value, binary
//   o_valid    : baseline established, o_bin meaningful
//   o_inc      : one-cycle pulse per accepted +1 step
//   o_err      : sticky illegal-transition flag
//   o_err_cnt  : saturating illegal-event count
// Optional feature macro:
//   COUNTER_GRAY_RX_ERRCNT_EN : adds o_err_cnt and its counter
module counter_gray_rx
    import counter_gray_rx_pkg::*;
#(
    parameter int unsigned BUS_WIDTH     = 4,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [BUS_WIDTH-1:0] i_gray,
    input  logic                 i_clr_err,
    output logic [BUS_WIDTH-1:0] o_bin,
    output logic                 o_valid,
    output logic                 o_inc,
    output logic                 o_err
`ifdef COUNTER_GRAY_RX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]  o_err_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    state_t               state;
    logic [BUS_WIDTH-1:0] g_q;
    logic [BUS_WIDTH-1:0] g_acc;
    logic [BUS_WIDTH-1:0] b_q;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [BUS_WIDTH-1:0] bin_plus1;
    logic                 same;
    logic                 stable_done;
    logic                 step_ok;
    logic                 illegal;

    counter_gray2bin #(
        .BUS_WIDTH(BUS_WIDTH)
    ) u_gray2bin (
        .gray(g_q),
        .bin (b_q)
    );

    // g_acc doubles as the stability reference while not tracking, so the
    // same comparison drives both the hold check and the stability count.
    always_comb begin
        same        = (g_q == g_acc);
        cnt_next    = same ? (cnt + CNT_W'(1)) : CNT_W'(1);
        stable_done = (cnt_next >= CNT_W'(STABLE_CYCLES));
        bin_plus1   = o_bin + BUS_WIDTH'(1);
        step_ok     = (b_q == bin_plus1);
        illegal     = (state == S_TRACK) && !same && !step_ok;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_INIT;
            g_q     <= '0;
            g_acc   <= '0;
            cnt     <= '0;
            o_bin   <= '0;
            o_valid <= 1'b0;
            o_inc   <= 1'b0;
        end else begin
            g_q   <= i_gray;
            o_inc <= 1'b0;
            case (state)
                S_INIT, S_RESYNC: begin
                    g_acc <= g_q;
                    if (stable_done) begin
                        cnt     <= '0;
                        o_bin   <= b_q;
                        o_valid <= 1'b1;
                        state   <= S_TRACK;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                S_TRACK: begin
                    if (same) begin
                        cnt <= '0;
                    end else if (step_ok) begin
                        o_bin <= b_q;
                        g_acc <= g_q;
                        o_inc <= 1'b1;
                    end else begin
                        // The offending sample is the first hit of the resync run.
                        g_acc   <= g_q;
                        cnt     <= CNT_W'(1);
                        o_valid <= 1'b0;
                        state   <= S_RESYNC;
                    end
                end
                default: begin
                    g_acc   <= '0;
                    cnt     <= '0;
                    o_valid <= 1'b0;
                    state   <= S_INIT;
                end
            endcase
        end
    end

    // Set has priority over clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (illegal) begin
            o_err <= 1'b1;
        end else if (i_clr_err) begin
            o_err <= 1'b0;
        end
    end

`ifdef COUNTER_GRAY_RX_ERRCNT_EN
    // An event coinciding with a clear leaves a count of one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err_cnt <= '0;
        end else if (illegal) begin
            if (i_clr_err) begin
                o_err_cnt <= ERRCNT_W'(1);
            end else if (o_err_cnt != '1) begin
                o_err_cnt <= o_err_cnt + ERRCNT_W'(1);
            end
        end else if (i_clr_err) begin
            o_err_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_counter_gray_rx.sv
module tb_counter_gray_rx;
    import counter_gray_rx_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] gray;
    logic       clr;
    logic [3:0] bin;
    logic       valid;
    logic       inc;
    logic       err;
`ifdef COUNTER_GRAY_RX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt;
`endif

    int checks;
    int errors;

    counter_gray_rx #(
        .BUS_WIDTH    (4),
        .STABLE_CYCLES(2)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_gray   (gray),
        .i_clr_err(clr),
        .o_bin    (bin),
        .o_valid  (valid),
        .o_inc    (inc),
        .o_err    (err)
`ifdef COUNTER_GRAY_RX_ERRCNT_EN
        ,
        .o_err_cnt(err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       clr;
        logic [3:0] gray;
        logic [3:0] bin;
        logic       valid;
        logic       inc;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        clr  = 1'b0;
        gray = 4'b0000;

        // {rst, clr, gray, expected bin, valid, inc, err} after the edge
        vecs.push_back('{1'b1, 1'b0, 4'b0110, 4'd0,  1'b0, 1'b0, 1'b0}); // reset
        vecs.push_back('{1'b0, 1'b0, 4'b0110, 4'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b0110, 4'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b0110, 4'd4,  1'b1, 1'b0, 1'b0}); // baseline 4
        vecs.push_back('{1'b0, 1'b0, 4'b0111, 4'd4,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b0101, 4'd5,  1'b1, 1'b1, 1'b0}); // 5
        vecs.push_back('{1'b0, 1'b0, 4'b0100, 4'd6,  1'b1, 1'b1, 1'b0}); // 6
        vecs.push_back('{1'b0, 1'b0, 4'b0100, 4'd7,  1'b1, 1'b1, 1'b0}); // 7
        vecs.push_back('{1'b0, 1'b0, 4'b0100, 4'd7,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b1000, 4'd7,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b1000, 4'd7,  1'b0, 1'b0, 1'b1}); // 7->15 skip
        vecs.push_back('{1'b0, 1'b1, 4'b1000, 4'd15, 1'b1, 1'b0, 1'b0}); // baseline 15, clear
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 4'd15, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 4'd0,  1'b1, 1'b1, 1'b0}); // wrap 15->0
        vecs.push_back('{1'b0, 1'b0, 4'b0001, 4'd0,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b0011, 4'd1,  1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b0101, 4'd2,  1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b0101, 4'd2,  1'b0, 1'b0, 1'b1}); // 2->6 multi-bit
        vecs.push_back('{1'b0, 1'b0, 4'b0101, 4'd6,  1'b1, 1'b0, 1'b1}); // resync 6
        vecs.push_back('{1'b0, 1'b1, 4'b0111, 4'd6,  1'b1, 1'b0, 1'b0}); // clear alone
        vecs.push_back('{1'b0, 1'b0, 4'b0111, 4'd6,  1'b0, 1'b0, 1'b1}); // 6->5 backward
        vecs.push_back('{1'b0, 1'b0, 4'b0111, 4'd5,  1'b1, 1'b0, 1'b1}); // resync 5
        vecs.push_back('{1'b0, 1'b1, 4'b0110, 4'd5,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b0110, 4'd5,  1'b0, 1'b0, 1'b1}); // 5->4 backward
        vecs.push_back('{1'b0, 1'b0, 4'b0110, 4'd4,  1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 4'b0110, 4'd4,  1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 4'd4,  1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'd4,  1'b0, 1'b0, 1'b1}); // event + clear: set wins
        vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'd0,  1'b1, 1'b0, 1'b0}); // clear alone
        vecs.push_back('{1'b0, 1'b0, 4'b1101, 4'd0,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b1101, 4'd0,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 4'b1101, 4'd9,  1'b1, 1'b0, 1'b1}); // baseline 9
        vecs.push_back('{1'b1, 1'b0, 4'b1101, 4'd0,  1'b0, 1'b0, 1'b0}); // mid-track reset
        vecs.push_back('{1'b0, 1'b0, 4'b1101, 4'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b1101, 4'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b1101, 4'd9,  1'b1, 1'b0, 1'b0});

        #2;
        foreach (vecs[i]) begin
            rst  = vecs[i].rst;
            clr  = vecs[i].clr;
            gray = vecs[i].gray;
            step();
            check("bin",   i, 32'(bin),   32'(vecs[i].bin));
            check("valid", i, 32'(valid), 32'(vecs[i].valid));
            check("inc",   i, 32'(inc),   32'(vecs[i].inc));
            check("err",   i, 32'(err),   32'(vecs[i].err));
        end

        // A bus that never holds still must not produce a baseline.
        rst = 1'b1; clr = 1'b0; gray = 4'b0000;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            gray = i[0] ? 4'b0011 : 4'b0001;
            step();
            check("unstable_valid", i, 32'(valid), 32'd0);
        end
        step();
        check("settle_valid_early", 0, 32'(valid), 32'd0);
        step();
        check("settle_valid", 0, 32'(valid), 32'd1);
        check("settle_bin",   0, 32'(bin),   32'd2);
        check("settle_inc",   0, 32'(inc),   32'd0);

`ifdef COUNTER_GRAY_RX_ERRCNT_EN
        rst = 1'b1; clr = 1'b0; gray = 4'b0000;
        step();
        check("errcnt_reset", 0, 32'(err_cnt), 32'd0);
        rst = 1'b0;
        step(); step(); step();
        check("errcnt_base_valid", 0, 32'(valid), 32'd1);
        // Alternating bin 0 / bin 2: every change is illegal; three cycles per event.
        for (int k = 0; k < 300; k++) begin
            gray = k[0] ? 4'b0000 : 4'b0011;
            step(); step(); step();
            if (k == 2) check("errcnt_three", k, 32'(err_cnt), 32'd3);
        end
        check("errcnt_sat", 0, 32'(err_cnt), 32'd255);
        gray = 4'b0011;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("errcnt_event_clear", 0, 32'(err_cnt), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("errcnt_clear", 0, 32'(err_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
